// File: rtl/vga_pkg.sv
// Shared VGA constants, swap FSM encoding and RGB332 colour expansion.
package vga_pkg;

    // 640x480@60 raster timing, in pixel clocks and lines
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_START_DEF = 144;
    localparam int V_START_DEF = 34;
    localparam int H_FP     = 16;
    localparam int V_FP     = 11;
    localparam int H_SYNC   = 96;
    localparam int V_SYNC   = 2;

    // Visible area and framebuffer geometry
    localparam int H_ACTIVE_DEF    = 640;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int FRAME_WORDS_DEF = 307200;
    localparam int ADDR_W_DEF      = 20;

    // Pixel pointer width: enough for one full buffer
    localparam int PTR_W = 19;

    // Buffer-swap handshake states
    typedef enum logic [1:0] {
        SWAP_IDLE,
        SWAP_PENDING,
        SWAP_ACK
    } swap_state_t;

    // RGB332 -> RGB888 by bit replication so full-scale codes map to 8'hFF
    function automatic logic [23:0] rgb332_expand(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6],
                p[4:2], p[4:2], p[4:3],
                p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

endpackage

// File: rtl/vga_frame_reader_sync_2ff.sv
// Two-flop synchronizer for a slow level signal into the pixel clock domain.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous level on the falling pixel edge, two stages deep
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vga_frame_reader.sv
// Framebuffer reader: raster counters -> RAM reads -> RGB888, with
// tear-free double-buffer swapping on a four-phase handshake.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int H_START     = H_START_DEF,
    parameter int V_START     = V_START_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [10:0]       h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              blank_n_in,
    input  logic              swap_req,
    input  logic [7:0]        fb_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd_en,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              front_sel,
    output logic              swap_ack
);

    localparam logic [10:0]       H_LO      = 11'(H_START);
    localparam logic [10:0]       H_HI      = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]        V_LO      = 10'(V_START);
    localparam logic [9:0]        V_HI      = 10'(V_START + V_ACTIVE);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] BACK_BASE = ADDR_W'(FRAME_WORDS);

    // Raster decode
    logic visible;
    logic frame_start;

    // Fetch stage
    logic [PTR_W-1:0]  pix_ptr_q, pix_ptr_d;
    logic              synced_q,  synced_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              rd_en_q,   rd_en_d;

    // Alignment pipeline
    logic              rd_dly_q;
    logic              hs_s1_q, hs_s2_q;
    logic              vs_s1_q, vs_s2_q;
    logic              bl_s1_q, bl_s2_q;
    logic [23:0]       rgb_q, rgb_d;

    // Swap handshake
    logic              req_s;
    swap_state_t       state_q, state_d;
    logic              front_sel_q;
    logic              do_swap;
    logic              swap_ack_c;

    sync_2ff u_req_sync (
        .clk_i (vga_clk),
        .rst_i (reset),
        .d_i   (swap_req),
        .q_o   (req_s)
    );

    // Decode the current counter position
    always_comb begin
        visible     = (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                      (v_cnt >= V_LO) && (v_cnt < V_HI);
        frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // Next pointer, address and read strobe for the current count
    always_comb begin
        synced_d  = synced_q | frame_start;
        pix_ptr_d = pix_ptr_q;
        if (frame_start) begin
            pix_ptr_d = '0;
        end else if (visible && synced_q && (pix_ptr_q != PTR_LAST)) begin
            // Saturates on the last pixel so the pointer never leaves the buffer
            pix_ptr_d = pix_ptr_q + PTR_W'(1);
        end
        fb_addr_d = ADDR_W'(pix_ptr_q) + (front_sel_q ? BACK_BASE : '0);
        rd_en_d   = visible & synced_q;
    end

    // Fetch-stage registers
    always_ff @(negedge vga_clk or posedge reset) begin
        if (reset) begin
            pix_ptr_q <= '0;
            synced_q  <= 1'b0;
            fb_addr_q <= '0;
            rd_en_q   <= 1'b0;
        end else begin
            pix_ptr_q <= pix_ptr_d;
            synced_q  <= synced_d;
            fb_addr_q <= fb_addr_d;
            rd_en_q   <= rd_en_d;
        end
    end

    // Colour for the pixel whose RAM data is on fb_data now; blank wins
    always_comb begin
        rgb_d = '0;
        if (bl_s1_q && rd_dly_q) begin
            rgb_d = rgb332_expand(fb_data);
        end
    end

    // Delay sync/blank and the fetch flag so they line up with the RGB register
    always_ff @(negedge vga_clk or posedge reset) begin
        if (reset) begin
            rd_dly_q <= 1'b0;
            hs_s1_q  <= 1'b1;
            hs_s2_q  <= 1'b1;
            vs_s1_q  <= 1'b1;
            vs_s2_q  <= 1'b1;
            bl_s1_q  <= 1'b0;
            bl_s2_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            rd_dly_q <= rd_en_q;
            hs_s1_q  <= hs_in;
            hs_s2_q  <= hs_s1_q;
            vs_s1_q  <= vs_in;
            vs_s2_q  <= vs_s1_q;
            bl_s1_q  <= blank_n_in;
            bl_s2_q  <= bl_s1_q;
            rgb_q    <= rgb_d;
        end
    end

    // Swap FSM state register
    always_ff @(negedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q <= SWAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Swap FSM next state: swaps are only taken at a frame start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SWAP_IDLE:    if (req_s)       state_d = SWAP_PENDING;
            SWAP_PENDING: if (frame_start) state_d = SWAP_ACK;
            SWAP_ACK:     if (!req_s)      state_d = SWAP_IDLE;
            default:                       state_d = SWAP_IDLE;
        endcase
    end

    // Swap FSM outputs
    always_comb begin
        do_swap    = (state_q == SWAP_PENDING) && frame_start;
        swap_ack_c = (state_q == SWAP_ACK);
    end

    // Front buffer select flips on the same edge that clears the pixel pointer
    always_ff @(negedge vga_clk or posedge reset) begin
        if (reset) begin
            front_sel_q <= 1'b0;
        end else if (do_swap) begin
            front_sel_q <= ~front_sel_q;
        end
    end

    assign fb_addr     = fb_addr_q;
    assign fb_rd_en    = rd_en_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = hs_s2_q;
    assign vga_vs      = vs_s2_q;
    assign vga_blank_n = bl_s2_q;
    assign front_sel   = front_sel_q;
    assign swap_ack    = swap_ack_c;

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Downstream consumer of `video_sync_generator`. Turns the raster counters and sync signals into framebuffer read requests and pipeline-aligned 24-bit RGB for the DAC. Framebuffer pixels are 8-bit RGB332 in a double-buffered synchronous RAM. Front/back buffer swaps are requested by the processor through a four-phase handshake and take effect only at frame start, so the display never tears.

## Interface
Parameters:
- `H_START`, 144, first visible `h_cnt`.
- `V_START`, 34, first visible `v_cnt`.
- `H_ACTIVE`, 640, visible pixels per line.
- `V_ACTIVE`, 480, visible lines.
- `FRAME_WORDS`, 307200, words per buffer; back buffer base address.
- `ADDR_W`, 20, framebuffer address width.

Ports:
- `vga_clk`  in  1  pixel clock; all state updates on its negedge.
- `reset`  in  1  reset, asynchronous, active-high.
- `h_cnt`  in  11  horizontal counter from the sync generator.
- `v_cnt`  in  10  vertical counter from the sync generator.
- `hs_in`, `vs_in`, `blank_n_in`  in  1 each  registered sync/blank from the sync generator; these lag the counters by 1 cycle.
- `swap_req`  in  1  processor-domain level request to swap buffers; asynchronous to `vga_clk`.
- `fb_data`  in  8  RAM read data; valid 1 cycle after `fb_addr`/`fb_rd_en`.
- `fb_addr`  out  ADDR_W  framebuffer read address.
- `fb_rd_en`  out  1  read strobe.
- `vga_r`, `vga_g`, `vga_b`  out  8 each  pixel colour.
- `vga_hs`, `vga_vs`, `vga_blank_n`  out  1 each  delayed sync/blank.
- `front_sel`  out  1  buffer currently displayed (0 = base 0, 1 = base FRAME_WORDS).
- `swap_ack`  out  1  handshake acknowledge.

## Operation
- Visible is `H_START <= h_cnt < H_START+H_ACTIVE` and `V_START <= v_cnt < V_START+V_ACTIVE`.
- Frame start is `h_cnt==0 && v_cnt==0`.
- Pixel pointer `pix_ptr` (19 bits):
  - cleared at frame start;
  - increments by 1 on each visible count;
  - `fb_addr` = `pix_ptr` + (`front_sel` ? FRAME_WORDS : 0), registered;
  - `fb_rd_en` is high for visible counts only.
- After reset, `fb_rd_en` is held 0 until the first frame start is seen (`synced` flag). This keeps the addressing frame-aligned if this block is reset mid-frame.
- Colour expansion from `fb_data` p:
  - R = {p[7:5],p[7:5],p[7:6]}
  - G = {p[4:2],p[4:2],p[4:3]}
  - B = {p[1:0],p[1:0],p[1:0],p[1:0]}
  - RGB is forced to 0 whenever delayed `blank_n` is 0 or the pixel was not fetched.
- `swap_req` passes through a 2-flop synchronizer, giving `req_s`.
- Swap FSM:
  - IDLE: `req_s`=1 -> PENDING.
  - PENDING: at frame start, toggle `front_sel` -> ACK. The toggle happens in the same cycle `pix_ptr` clears, so the whole new frame reads the new buffer.
  - ACK: `swap_ack`=1; `req_s`=0 -> IDLE (`swap_ack`=0).
  - A request arriving on the same cycle as a frame start waits for the next frame start. Swaps only happen from PENDING.
- Reset values:
  - `fb_addr`=0, `fb_rd_en`=0, `vga_r`/`vga_g`/`vga_b`=0.
  - `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0.
  - `front_sel`=0, `swap_ack`=0, FSM=IDLE, `synced`=0, synchronizer flops=0.

## Timing
- Let counters hold (h,v) after negedge n:
  - `fb_addr` for (h,v) is registered at edge n+1;
  - RAM returns `fb_data` at edge n+2;
  - RGB is registered at edge n+3.
- Counter-to-RGB latency is 3 cycles.
- `hs_in`/`vs_in`/`blank_n_in` (valid at n+1) go through a 2-stage delay, so the outputs at n+3 are aligned with RGB.
- `swap_req` to PENDING takes 3 cycles (sync + FSM).
- Swap completes within one frame (≤ 800×525 cycles) after that.
- `swap_ack` deasserts 3 cycles after `swap_req` falls.
- `pix_ptr` reaches 307199 on the last visible pixel and never exceeds it. No wrap occurs within a frame.

## Structure
- Shared package `vga_pkg`:
  - timing constants 800/525/144/34/16/11/96/2;
  - H/V active sizes and FRAME_WORDS;
  - swap FSM state enum.
- One sub-module, `sync_2ff`, used for the `swap_req` synchronizer.
- Everything else stays in a single module.

## Test plan
- Reset, then drive counters from a sync-generator model. Expect:
  - no `fb_rd_en` before the first (0,0);
  - first `fb_addr`=0 at (144,34) +1 cycle;
  - last visible `fb_addr`=307199 at (783,513) +1 cycle.
- RAM model returning `fb_data`=8'hE0 -> RGB = FF/00/00 three cycles after the counter. `fb_data`=8'h1C -> 00/FF/00. `fb_data`=8'h03 -> 00/00/FF.
- Blanking: during `h_cnt` in 0..143 and 784..799, RGB=0 and `fb_rd_en`=0. `vga_hs` is low for 96 cycles, 2 cycles behind `hs_in`.
- Swap: raise `swap_req` mid-frame. Expect:
  - `front_sel` toggles exactly at the next (0,0);
  - the first visible address of that frame is 307200;
  - `swap_ack`=1 until 3 cycles after `swap_req` falls.
- `swap_req` rising at the frame-start cycle -> swap is deferred one full frame.
- Assert `reset` mid-frame for 5 cycles:
  - all outputs take their reset values;
  - no reads occur until the next (0,0);
  - addressing resumes from 0 (`front_sel`=0).
